reversi_move_scanner: RTL and testbench

Sequential, parametrised Reversi move validator. It scans the eight rays from a candidate square one cell per clock and returns a per-direction valid mask, per-direction end points and a total flip count through a start/done handshake. It supersedes the flat eight-way combinational checker: board size is a parameter, cost is one shared ray walker instead of eight, and it adds early-exit and flip counting. It sits between the board register file and the move-apply/flip FSM.

---
 rtl/reversi_move_scanner_pkg.sv | 34 +++
 rtl/reversi_move_scanner_ray_step.sv | 32 +++
 rtl/reversi_move_scanner.sv | 151 +++++++++++++++
 tb/tb_reversi_move_scanner.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/reversi_move_scanner_pkg.sv
// Shared Reversi types: cell encodings, ray directions and their unit deltas,
// plus the scanner FSM state type.
package reversi_pkg;

    localparam logic [1:0] CELL_EMPTY = 2'b00;
    localparam logic [1:0] CELL_BLACK = 2'b01;
    localparam logic [1:0] CELL_WHITE = 2'b10;

    typedef enum logic [2:0] {
        DIR_N, DIR_NE, DIR_E, DIR_SE, DIR_S, DIR_SW, DIR_W, DIR_NW
    } dir_t;

    typedef enum logic [1:0] {
        ST_IDLE, ST_ORIGIN, ST_WALK, ST_DONE
    } state_t;

    // y grows downward, so north is -1
    function automatic logic signed [1:0] dir_dx(dir_t d);
        case (d)
            DIR_NE, DIR_E, DIR_SE: return 2'sd1;
            DIR_SW, DIR_W, DIR_NW: return -2'sd1;
            default:               return 2'sd0;
        endcase
    endfunction

    function automatic logic signed [1:0] dir_dy(dir_t d);
        case (d)
            DIR_N, DIR_NE, DIR_NW: return -2'sd1;
            DIR_SE, DIR_S, DIR_SW: return 2'sd1;
            default:               return 2'sd0;
        endcase
    endfunction

endpackage

// File: rtl/reversi_move_scanner_ray_step.sv
// Combinational one-cell ray advance: next cursor along a direction and
// whether that next cursor has left the board.
module reversi_ray_step
    import reversi_pkg::*;
#(
    parameter int BOARD_DIM = 8,
    parameter int COORD_W   = $clog2(BOARD_DIM)
) (
    input  logic signed [COORD_W:0] cur_x,
    input  logic signed [COORD_W:0] cur_y,
    input  dir_t                    dir,
    output logic signed [COORD_W:0] nxt_x,
    output logic signed [COORD_W:0] nxt_y,
    output logic                    off_board
);

    localparam logic [COORD_W:0] DIM_EXT = (COORD_W + 1)'(BOARD_DIM);

    logic signed [1:0] dx;
    logic signed [1:0] dy;

    always_comb begin
        dx = dir_dx(dir);
        dy = dir_dy(dir);
        nxt_x = cur_x + {{(COORD_W - 1){dx[1]}}, dx};
        nxt_y = cur_y + {{(COORD_W - 1){dy[1]}}, dy};
        // Negative values have the sign bit set, so an unsigned compare
        // against the edge length catches both sides of the board.
        off_board = ($unsigned(nxt_x) >= DIM_EXT) || ($unsigned(nxt_y) >= DIM_EXT);
    end

endmodule

// File: rtl/reversi_move_scanner.sv
// Sequential Reversi move validator: walks the eight rays from a candidate
// square one cell per clock, reporting per-direction captures and flip count.
module reversi_move_scanner
    import reversi_pkg::*;
#(
    parameter int BOARD_DIM = 8,
    parameter int COORD_W   = $clog2(BOARD_DIM),
    parameter int FLIP_W    = $clog2(8 * BOARD_DIM)
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               start,
    output logic                               ready,
    input  logic [COORD_W-1:0]                 x,
    input  logic [COORD_W-1:0]                 y,
    input  logic                               player_black,
    input  logic                               early_exit,
    input  logic [2*BOARD_DIM*BOARD_DIM-1:0]   board,
    output logic                               done,
    output logic [7:0]                         valids,
    output logic [16*COORD_W-1:0]              end_points,
    output logic                               any_valid,
    output logic [FLIP_W-1:0]                  flip_count
);

    localparam int IDX_W = $clog2(2 * BOARD_DIM * BOARD_DIM);

    function automatic logic [IDX_W-1:0] cell_base(input logic [COORD_W-1:0] cx,
                                                   input logic [COORD_W-1:0] cy);
        return IDX_W'((int'(cy) * BOARD_DIM + int'(cx)) * 2);
    endfunction

    state_t state, state_next;

    logic [2*BOARD_DIM*BOARD_DIM-1:0] board_q;
    logic [COORD_W-1:0]               org_x, org_y;
    logic                             player_q, early_q;
    dir_t                             dir_q;
    logic signed [COORD_W:0]          cur_x, cur_y;
    logic                             cur_off;
    logic [COORD_W-1:0]               run_q;

    logic [1:0]              own_cell, opp_cell, cur_cell, org_cell;
    logic [IDX_W-1:0]        cur_idx;
    logic                    org_busy, ray_continue, ray_end, ray_hit;
    logic signed [COORD_W:0] base_x, base_y, step_x, step_y;
    dir_t                    step_dir;
    logic                    step_off;

    always_comb begin
        own_cell     = player_q ? CELL_BLACK : CELL_WHITE;
        opp_cell     = player_q ? CELL_WHITE : CELL_BLACK;
        cur_idx      = cur_off ? '0 : cell_base(cur_x[COORD_W-1:0], cur_y[COORD_W-1:0]);
        cur_cell     = cur_off ? CELL_EMPTY : board_q[cur_idx +: 2];
        org_cell     = board_q[cell_base(org_x, org_y) +: 2];
        org_busy     = (org_cell == CELL_BLACK) || (org_cell == CELL_WHITE);
        ray_continue = (state == ST_WALK) && !cur_off && (cur_cell == opp_cell);
        ray_end      = (state == ST_WALK) && !ray_continue;
        ray_hit      = ray_end && !cur_off && (cur_cell == own_cell) && (run_q != '0);
        // A finished ray restarts from the origin in the next direction in the same cycle
        if (ray_continue) begin
            base_x   = cur_x;
            base_y   = cur_y;
            step_dir = dir_q;
        end else begin
            base_x   = {1'b0, org_x};
            base_y   = {1'b0, org_y};
            step_dir = (state == ST_WALK) ? dir_t'(3'(dir_q + 3'd1)) : DIR_N;
        end
    end

    reversi_ray_step #(
        .BOARD_DIM (BOARD_DIM),
        .COORD_W   (COORD_W)
    ) u_ray_step (
        .cur_x     (base_x),
        .cur_y     (base_y),
        .dir       (step_dir),
        .nxt_x     (step_x),
        .nxt_y     (step_y),
        .off_board (step_off)
    );

    always_ff @(posedge clk) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:   if (start) state_next = ST_ORIGIN;
            ST_ORIGIN: state_next = org_busy ? ST_DONE : ST_WALK;
            ST_WALK:   if (ray_end && (dir_q == DIR_NW || (early_q && ray_hit)))
                           state_next = ST_DONE;
            ST_DONE:   state_next = ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
    end

    // Result registers: cleared on reset and on every accepted start
    always_ff @(posedge clk) begin
        if (reset) begin
            ready      <= 1'b1;
            done       <= 1'b0;
            valids     <= '0;
            end_points <= '0;
            any_valid  <= 1'b0;
            flip_count <= '0;
        end else begin
            ready <= (state_next == ST_IDLE);
            done  <= (state_next == ST_DONE);
            if (state == ST_IDLE && start) begin
                valids     <= '0;
                end_points <= '0;
                any_valid  <= 1'b0;
                flip_count <= '0;
            end else if (ray_hit) begin
                valids[dir_q] <= 1'b1;
                any_valid     <= 1'b1;
                end_points[int'(dir_q) * 2 * COORD_W +: 2 * COORD_W]
                    <= {cur_y[COORD_W-1:0], cur_x[COORD_W-1:0]};
                flip_count    <= flip_count + FLIP_W'(run_q);
            end
        end
    end

    always_ff @(posedge clk) begin
        case (state)
            ST_IDLE: begin
                if (start) begin
                    board_q  <= board;
                    org_x    <= x;
                    org_y    <= y;
                    player_q <= player_black;
                    early_q  <= early_exit;
                end
            end
            ST_ORIGIN, ST_WALK: begin
                cur_x   <= step_x;
                cur_y   <= step_y;
                cur_off <= step_off;
                run_q   <= ray_continue ? run_q + 1'b1 : '0;
                if (state == ST_ORIGIN) dir_q <= DIR_N;
                else if (ray_end)       dir_q <= dir_t'(3'(dir_q + 3'd1));
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_reversi_move_scanner.sv
// Directed and random scans of reversi_move_scanner against a behavioural
// ray-walking reference model, with a queue-based scoreboard.
module tb_reversi_move_scanner;

    localparam int D  = 8;
    localparam int CW = 3;
    localparam int FW = 6;

    typedef logic [2*D*D-1:0] brd_t;
    typedef struct {
        logic [7:0]      valids;
        logic [16*CW-1:0] ep;
        logic [FW-1:0]   flips;
        int              cycles;
    } exp_t;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              start = 1'b0;
    logic              ready;
    logic [CW-1:0]     x_in = '0;
    logic [CW-1:0]     y_in = '0;
    logic              player_black = 1'b1;
    logic              early_exit = 1'b0;
    brd_t              board = '0;
    logic              done;
    logic [7:0]        valids;
    logic [16*CW-1:0]  end_points;
    logic              any_valid;
    logic [FW-1:0]     flip_count;

    int n_chk = 0;
    int n_err = 0;
    exp_t sb[$];

    reversi_move_scanner #(.BOARD_DIM(D)) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .ready        (ready),
        .x            (x_in),
        .y            (y_in),
        .player_black (player_black),
        .early_exit   (early_exit),
        .board        (board),
        .done         (done),
        .valids       (valids),
        .end_points   (end_points),
        .any_valid    (any_valid),
        .flip_count   (flip_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_chk++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic brd_t put(input brd_t b, input int cx, input int cy, input logic [1:0] v);
        b[2*(cy*D+cx) +: 2] = v;
        return b;
    endfunction

    function automatic exp_t model(input brd_t b, input int ox, input int oy,
                                   input bit blk, input bit early);
        int dxs[8] = '{0, 1, 1, 1, 0, -1, -1, -1};
        int dys[8] = '{-1, -1, 0, 1, 1, 1, 0, -1};
        logic [1:0] own, opp, c;
        int w, cx, cy, run;
        exp_t e;
        e.valids = '0; e.ep = '0; e.flips = '0;
        own = blk ? 2'b01 : 2'b10;
        opp = blk ? 2'b10 : 2'b01;
        c = b[2*(oy*D+ox) +: 2];
        if (c == 2'b01 || c == 2'b10) begin
            e.cycles = 2;
            return e;
        end
        w = 0;
        for (int d = 0; d < 8; d++) begin
            cx = ox + dxs[d];
            cy = oy + dys[d];
            run = 0;
            forever begin
                w++;
                if (cx < 0 || cx >= D || cy < 0 || cy >= D) break;
                c = b[2*(cy*D+cx) +: 2];
                if (c == opp) begin
                    run++;
                    cx += dxs[d];
                    cy += dys[d];
                end else begin
                    if (c == own && run > 0) begin
                        e.valids[d] = 1'b1;
                        e.ep[d*2*CW +: CW]      = CW'(cx);
                        e.ep[d*2*CW + CW +: CW] = CW'(cy);
                        e.flips = e.flips + FW'(run);
                    end
                    break;
                end
            end
            if (early && e.valids[d]) break;
        end
        e.cycles = w + 2;
        return e;
    endfunction

    // Drives one scan, waits for done and scores it; returns the observed done cycle
    task automatic do_scan(input brd_t b, input int ox, input int oy, input bit blk,
                           input bit early, input string tag, output int cyc);
        exp_t e;
        int n;
        bit got;
        sb.push_back(model(b, ox, oy, blk, early));
        @(negedge clk);
        board = b; x_in = CW'(ox); y_in = CW'(oy);
        player_black = blk; early_exit = early; start = 1'b1;
        @(posedge clk); #1;
        check({tag, ".ready_low"}, 64'(ready), 64'd0);
        @(negedge clk);
        start = 1'b0;
        got = 0; n = 0;
        while (!got && n < 200) begin
            @(posedge clk); #1;
            n++;
            if (done) got = 1;
        end
        cyc = n + 1;
        check({tag, ".done_seen"}, 64'(got), 64'd1);
        e = sb.pop_front();
        if (got) begin
            check({tag, ".valids"}, 64'(valids), 64'(e.valids));
            check({tag, ".end_points"}, 64'(end_points), 64'(e.ep));
            check({tag, ".flips"}, 64'(flip_count), 64'(e.flips));
            check({tag, ".any"}, 64'(any_valid), 64'(|e.valids));
            check({tag, ".cycle"}, 64'(cyc), 64'(e.cycles));
        end
        @(posedge clk); #1;
        check({tag, ".done_pulse"}, 64'(done), 64'd0);
        check({tag, ".ready_back"}, 64'(ready), 64'd1);
    endtask

    initial begin
        brd_t opening, b;
        int cyc, cyc_full, n;
        bit seen;

        opening = '0;
        opening = put(opening, 3, 3, 2'b10);
        opening = put(opening, 4, 3, 2'b01);
        opening = put(opening, 3, 4, 2'b01);
        opening = put(opening, 4, 4, 2'b10);

        repeat (3) @(posedge clk);
        #1;
        check("rst.ready", 64'(ready), 64'd1);
        check("rst.done", 64'(done), 64'd0);
        check("rst.valids", 64'(valids), 64'd0);
        check("rst.flips", 64'(flip_count), 64'd0);
        @(negedge clk);
        reset = 1'b0;

        do_scan(opening, 2, 3, 1'b1, 1'b0, "open", cyc);
        check("open.valids_const", 64'(valids), 64'h04);
        check("open.ep2_const", 64'(end_points[2*2*CW +: 2*CW]), 64'({3'd3, 3'd4}));
        check("open.cycle_const", 64'(cyc), 64'd11);

        do_scan(opening, 3, 3, 1'b1, 1'b0, "occupied", cyc);
        check("occupied.cycle_const", 64'(cyc), 64'd2);

        b = put('0, 1, 1, 2'b10);
        do_scan(b, 0, 0, 1'b1, 1'b0, "corner", cyc);

        b = '0;
        for (int i = 1; i <= 6; i++) b = put(b, i, 0, 2'b10);
        b = put(b, 7, 0, 2'b01);
        do_scan(b, 0, 0, 1'b1, 1'b0, "row0", cyc);
        check("row0.flips_const", 64'(flip_count), 64'd6);

        b = '0;
        b = put(b, 4, 3, 2'b10); b = put(b, 5, 3, 2'b01);
        b = put(b, 3, 4, 2'b10); b = put(b, 3, 5, 2'b01);
        do_scan(b, 3, 3, 1'b1, 1'b0, "cross", cyc_full);
        check("cross.valids_const", 64'(valids), 64'h14);
        do_scan(b, 3, 3, 1'b1, 1'b1, "cross_early", cyc);
        check("cross_early.valids_const", 64'(valids), 64'h04);
        check("cross_early.sooner", 64'(cyc < cyc_full), 64'd1);

        do_scan(opening, 5, 3, 1'b0, 1'b0, "white", cyc);

        for (int i = 0; i < 8; i++) begin
            int ox, oy;
            b = '0;
            for (int c = 0; c < D*D; c++) b[2*c +: 2] = 2'($urandom_range(0, 3));
            ox = $urandom_range(0, D-1);
            oy = $urandom_range(0, D-1);
            if (i < 6) b = put(b, ox, oy, 2'b00);
            do_scan(b, ox, oy, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), "rand", cyc);
        end

        // start held high through a scan while the board changes underneath
        sb.push_back(model(opening, 2, 3, 1'b1, 1'b0));
        @(negedge clk);
        board = opening; x_in = 3'd2; y_in = 3'd3; player_black = 1'b1;
        early_exit = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        board = '1; x_in = 3'd0; y_in = 3'd0;
        seen = 0; n = 0;
        while (!seen && n < 200) begin
            @(posedge clk); #1;
            n++;
            if (n == 4) check("hold.ready_low", 64'(ready), 64'd0);
            if (done) seen = 1;
        end
        start = 1'b0;
        check("hold.done_seen", 64'(seen), 64'd1);
        begin
            exp_t e;
            e = sb.pop_front();
            check("hold.valids", 64'(valids), 64'(e.valids));
            check("hold.flips", 64'(flip_count), 64'(e.flips));
            check("hold.cycle", 64'(n + 1), 64'(e.cycles));
        end
        @(posedge clk); #1;

        // reset in idle after a capturing scan clears the results
        @(negedge clk); reset = 1'b1;
        @(posedge clk); #1;
        check("rst_idle.valids", 64'(valids), 64'd0);
        check("rst_idle.ep", 64'(end_points), 64'd0);
        check("rst_idle.flips", 64'(flip_count), 64'd0);
        check("rst_idle.any", 64'(any_valid), 64'd0);
        @(negedge clk); reset = 1'b0;

        // reset during WALK aborts with no done pulse
        @(negedge clk);
        board = opening; x_in = 3'd2; y_in = 3'd3; player_black = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        @(negedge clk); start = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk); reset = 1'b1;
        @(posedge clk); #1;
        check("rst_walk.ready", 64'(ready), 64'd1);
        check("rst_walk.done", 64'(done), 64'd0);
        check("rst_walk.valids", 64'(valids), 64'd0);
        check("rst_walk.flips", 64'(flip_count), 64'd0);
        @(negedge clk); reset = 1'b0;
        seen = 0;
        repeat (20) begin
            @(posedge clk); #1;
            if (done) seen = 1;
        end
        check("rst_walk.no_done", 64'(seen), 64'd0);

        do_scan(opening, 2, 3, 1'b1, 1'b0, "recover", cyc);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
